// File: rtl/atpg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atpg_pkg                                                             |
// | Shared FSM encoding, key/hold defaults and GPIO pad index map.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package atpg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_ARMED = 3'd2,
        ST_ATPG  = 3'd3,
        ST_LOCK  = 3'd4
    } atpg_state_e;

    localparam logic [7:0] KEY_VAL_DEF  = 8'hA5;
    localparam int         HOLD_CYC_DEF = 16;

    localparam int GP_SE  = 0;
    localparam int GP_SI0 = 1;
    localparam int GP_SI1 = 2;
    localparam int GP_SO0 = 3;
    localparam int GP_SO1 = 4;

endpackage
`default_nettype wire

// File: rtl/atpg_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atpg_sync2                                                           |
// | Two-flop synchronizer for asynchronous test pad inputs.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module atpg_sync2 (
    input  logic clk,
    input  logic rstz,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/atpg_mode_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | atpg_mode_ctl                                                        |
// | Serial-key gated ATPG entry; routes GPIO pads to the scan chains.    |
// | Option macro ATPG_FAIL_LIMIT_EN: sticky LOCK after 3 bad keys.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module atpg_mode_ctl
    import atpg_pkg::*;
#(
    parameter int               KEY_W    = 8,
    parameter logic [KEY_W-1:0] KEY_VAL  = KEY_VAL_DEF,
    parameter int               HOLD_CYC = HOLD_CYC_DEF,
    parameter int               NCHAIN   = 2
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic              tst_i,
    input  logic              scl_i,
    input  logic              sda_i,
    input  logic [4:0]        gpio_i,
    input  logic [NCHAIN-1:0] so_i,
    output logic              atpg_en,
    output logic              scan_en,
    output logic [NCHAIN-1:0] si_o,
    output logic [4:0]        gpio_o,
    output logic [4:0]        gpio_oe
);

    localparam int CNT_W  = $clog2(KEY_W + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    logic tst_s, scl_s, sda_s;

    atpg_sync2 u_sync_tst (.clk(clk), .rstz(rstz), .d_i(tst_i), .q_o(tst_s));
    atpg_sync2 u_sync_scl (.clk(clk), .rstz(rstz), .d_i(scl_i), .q_o(scl_s));
    atpg_sync2 u_sync_sda (.clk(clk), .rstz(rstz), .d_i(sda_i), .q_o(sda_s));

    atpg_state_e        state_q, state_d;
    logic [KEY_W-1:0]   key_sr_q, key_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               scl_prev_q;
    logic               scl_rise;
    logic [KEY_W-1:0]   key_next;
    logic               fail_inc;
    logic               lock_hold;

    assign scl_rise = scl_s & ~scl_prev_q;
    assign key_next = {key_sr_q[KEY_W-2:0], sda_s};

    // TST low has priority over everything, so a coincident SCL rise is dropped.
    always_comb begin
        state_d  = state_q;
        key_sr_d = key_sr_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        fail_inc = 1'b0;
        if (!tst_s) begin
            key_sr_d = '0;
            cnt_d    = '0;
            hold_d   = '0;
            state_d  = (state_q == ST_LOCK && lock_hold) ? ST_LOCK : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_SHIFT;
                ST_SHIFT: begin
                    if (scl_rise) begin
                        key_sr_d = key_next;
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(KEY_W - 1)) begin
                            if (key_next == KEY_VAL) begin
                                state_d = ST_ARMED;
                                hold_d  = '0;
                            end else begin
                                state_d  = ST_LOCK;
                                fail_inc = 1'b1;
                            end
                        end
                    end
                end
                ST_ARMED: begin
                    if (scl_rise)
                        state_d = ST_LOCK;
                    else if (hold_q == HOLD_W'(HOLD_CYC - 1))
                        state_d = ST_ATPG;
                    else
                        hold_d = hold_q + HOLD_W'(1);
                end
                ST_ATPG:  state_d = ST_ATPG;
                ST_LOCK:  state_d = ST_LOCK;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q    <= ST_IDLE;
            key_sr_q   <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            scl_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_sr_q   <= key_sr_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            scl_prev_q <= scl_s;
        end
    end

`ifdef ATPG_FAIL_LIMIT_EN
    logic [1:0] fail_q, fail_d;
    logic       unused_bits;

    always_comb begin
        fail_d = fail_q;
        if (fail_inc && fail_q != 2'd3)
            fail_d = fail_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz)
            fail_q <= 2'd0;
        else
            fail_q <= fail_d;
    end

    assign lock_hold   = (fail_q == 2'd3);
    assign unused_bits = ^{key_sr_q[KEY_W-1], gpio_i[GP_SO1], gpio_i[GP_SO0]};
`else
    logic unused_bits;
    assign lock_hold   = 1'b0;
    assign unused_bits = ^{key_sr_q[KEY_W-1], gpio_i[GP_SO1], gpio_i[GP_SO0], fail_inc};
`endif

    // Outputs decode only the registered state, so reset and exit are glitch-free.
    always_comb begin
        atpg_en = (state_q == ST_ATPG);
        scan_en = 1'b0;
        si_o    = '0;
        gpio_o  = '0;
        gpio_oe = '0;
        if (state_q == ST_ATPG) begin
            scan_en         = gpio_i[GP_SE];
            si_o[0]         = gpio_i[GP_SI0];
            si_o[1]         = gpio_i[GP_SI1];
            gpio_o[GP_SO0]  = so_i[0];
            gpio_o[GP_SO1]  = so_i[1];
            gpio_oe[GP_SO0] = 1'b1;
            gpio_oe[GP_SO1] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atpg_mode_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_atpg_mode_ctl                                                     |
// | Directed, scoreboarded bench for the ATPG entry controller.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_atpg_mode_ctl;
    import atpg_pkg::*;

    logic       clk    = 1'b0;
    logic       rstz   = 1'b0;
    logic       tst_i  = 1'b0;
    logic       scl_i  = 1'b0;
    logic       sda_i  = 1'b0;
    logic [4:0] gpio_i = 5'b0;
    logic [1:0] so_i   = 2'b0;
    logic       atpg_en, scan_en;
    logic [1:0] si_o;
    logic [4:0] gpio_o, gpio_oe;

    atpg_mode_ctl dut (
        .clk(clk), .rstz(rstz), .tst_i(tst_i), .scl_i(scl_i), .sda_i(sda_i),
        .gpio_i(gpio_i), .so_i(so_i), .atpg_en(atpg_en), .scan_en(scan_en),
        .si_o(si_o), .gpio_o(gpio_o), .gpio_oe(gpio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %h required <entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
                $error("tag %s observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [15:0] outs();
        return {2'b0, atpg_en, scan_en, si_o, gpio_o, gpio_oe};
    endfunction

    function automatic logic [15:0] st();
        return {13'b0, dut.state_q};
    endfunction

    // Reference output pattern: everything 0 unless in scan mode.
    function automatic logic [15:0] mk(input logic en, input logic [4:0] g, input logic [1:0] s);
        if (!en) return 16'h0;
        return {2'b0, 1'b1, g[0], g[2:1], s, 3'b000, 5'b11000};
    endfunction

    task automatic send_bit(input logic b);
        sda_i = b;
        tick(2);
        scl_i = 1'b1;
        tick(3);
        scl_i = 1'b0;
        tick(3);
    endtask

    task automatic send_key(input logic [7:0] k);
        for (int i = 7; i >= 0; i--) send_bit(k[i]);
    endtask

    task automatic tst_cycle();
        tst_i = 1'b0;
        tick(4);
        tst_i = 1'b1;
        tick(4);
    endtask

    // Last SCL rise +3 clocks -> ARMED, +HOLD_CYC more -> ATPG; send_key returns 6 ticks after it.
    task automatic entry_check(input string tag);
        tick(12);
        push({tag, "_pre"}, 16'h0);
        check(outs());
        tick(1);
        push(tag, mk(1'b1, gpio_i, so_i));
        check(outs());
    endtask

    initial begin
        tick(2);
        push("reset_outs", 16'h0);
        check(outs());
        push("reset_state", {13'b0, ST_IDLE});
        check(st());

        rstz = 1'b1;
        tick(1);
        tst_i = 1'b1;
        tick(2);
        push("tst_lat2", {13'b0, ST_IDLE});
        check(st());
        tick(1);
        push("tst_lat3", {13'b0, ST_SHIFT});
        check(st());
        tick(1);

        send_key(8'hA5);
        entry_check("good_key");

        gpio_i = 5'b00111;
        so_i   = 2'b10;
        tick(1);
        push("scan_route_a", mk(1'b1, 5'b00111, 2'b10));
        check(outs());
        gpio_i = 5'b11010;
        so_i   = 2'b01;
        tick(1);
        push("scan_route_b", mk(1'b1, 5'b11010, 2'b01));
        check(outs());

        tst_i = 1'b0;
        tick(2);
        push("tst_fall_hold", mk(1'b1, 5'b11010, 2'b01));
        check(outs());
        tick(1);
        push("tst_fall_exit", 16'h0);
        check(outs());
        gpio_i = 5'b0;
        so_i   = 2'b0;
        tick(2);
        tst_i = 1'b1;
        tick(4);

        send_key(8'h5A);
        tick(14);
        push("wrong_key", 16'h0);
        check(outs());
        push("wrong_key_state", {13'b0, ST_LOCK});
        check(st());
        send_key(8'hA5);
        tick(14);
        push("lock_holds", 16'h0);
        check(outs());

        tst_cycle();
        send_key(8'hA5);
        entry_check("retry_entry");

        tst_cycle();
        for (int i = 7; i >= 3; i--) send_bit(8'hA5 >> i);
        tst_cycle();
        send_key(8'hA5);
        entry_check("midkey_clear");

        tst_cycle();
        send_key(8'hA5);
        send_bit(1'b1);
        tick(20);
        push("armed_extra_scl", 16'h0);
        check(outs());
        push("armed_extra_state", {13'b0, ST_LOCK});
        check(st());

        tst_cycle();
        send_key(8'hA5);
        entry_check("pre_rst_entry");
        gpio_i = 5'b00111;
        tick(1);
        #1;
        rstz = 1'b0;
        #1;
        push("rst_async_outs", 16'h0);
        check(outs());
        push("rst_async_state", {13'b0, ST_IDLE});
        check(st());
        gpio_i = 5'b0;
        tick(1);
        rstz = 1'b1;
        tick(1);

        tst_cycle();
        for (int k = 0; k < 3; k++) begin
            send_key(8'h5A);
            tst_cycle();
        end
        send_key(8'hA5);
        tick(13);
`ifdef ATPG_FAIL_LIMIT_EN
        push("fail_limit_lock", 16'h0);
        check(outs());
        tick(1);
        rstz = 1'b0;
        tick(1);
        rstz = 1'b1;
        tst_cycle();
        send_key(8'hA5);
        entry_check("after_limit_rst");
`else
        push("fourth_key", mk(1'b1, gpio_i, so_i));
        check(outs());
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
